mem_except_unit: RTL

Exception resolver between the MEM stage and the CP0 register file. Each cycle it collects the exception flags carried by the instruction in MEM and the pending hardware/timer interrupts. It picks the highest-priority cause, registers the cause code, faulting PC, delay-slot flag and bad address for CP0 to commit, and drives the pipeline flush and redirect PC. It forwards an in-flight CP0 write so that interrupt masking and the ERET target always use current Status/Cause/EPC values.

---
 rtl/mem_except_unit_pkg.sv | 32 +++
 rtl/mem_except_unit_exc_prio_enc.sv | 46 ++++
 rtl/mem_except_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mem_except_unit_pkg.sv
// Shared constants for the MEM-stage exception resolver: cause codes, CP0 register
// numbers, exception flag bit positions and the resolver's internal types.
package mem_except_unit_pkg;

    localparam logic [31:0] EXC_NONE = 32'h0000_0000;
    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] CP0_REG_STATUS = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_REG_EPC    = 5'd14;

    localparam int unsigned FLAG_ADEL_IF = 7;
    localparam int unsigned FLAG_RI      = 6;
    localparam int unsigned FLAG_OV      = 5;
    localparam int unsigned FLAG_SYS     = 4;
    localparam int unsigned FLAG_BP      = 3;
    localparam int unsigned FLAG_ERET    = 2;
    localparam int unsigned FLAG_ADEL_LD = 1;
    localparam int unsigned FLAG_ADES_ST = 0;

    typedef enum logic [1:0] {BadHold, BadPc, BadMem} bad_sel_e;

    typedef enum logic {StRun, StFlush} state_e;

endpackage

// File: rtl/mem_except_unit_exc_prio_enc.sv
// Combinational priority encoder: picks the highest-priority exception cause for the
// instruction in MEM and says where BadVAddr comes from.
module exc_prio_enc
    import mem_except_unit_pkg::*;
(
    input  logic        int_pending_i,
    input  logic [7:0]  flags_i,
    output logic        valid_o,
    output logic [31:0] code_o,
    output bad_sel_e    bad_sel_o,
    output logic        eret_o
);

    always_comb begin
        valid_o   = 1'b1;
        code_o    = EXC_NONE;
        bad_sel_o = BadHold;
        eret_o    = 1'b0;
        if (int_pending_i) begin
            code_o = EXC_INT;
        end else if (flags_i[FLAG_ADEL_IF]) begin
            code_o    = EXC_ADEL;
            bad_sel_o = BadPc;
        end else if (flags_i[FLAG_RI]) begin
            code_o = EXC_RI;
        end else if (flags_i[FLAG_OV]) begin
            code_o = EXC_OV;
        end else if (flags_i[FLAG_SYS]) begin
            code_o = EXC_SYS;
        end else if (flags_i[FLAG_BP]) begin
            code_o = EXC_BP;
        end else if (flags_i[FLAG_ADEL_LD]) begin
            code_o    = EXC_ADEL;
            bad_sel_o = BadMem;
        end else if (flags_i[FLAG_ADES_ST]) begin
            code_o    = EXC_ADES;
            bad_sel_o = BadMem;
        end else if (flags_i[FLAG_ERET]) begin
            code_o = EXC_ERET;
            eret_o = 1'b1;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/mem_except_unit.sv
// Exception resolver between MEM and CP0: forwards in-flight CP0 writes, selects the
// winning cause, and registers the cause, faulting PC, BadVAddr, flush and redirect.
module mem_except_unit
    import mem_except_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR      = 32'hBFC0_0380,
    parameter logic [4:0]  CP0_STATUS_ADDR = CP0_REG_STATUS,
    parameter logic [4:0]  CP0_CAUSE_ADDR  = CP0_REG_CAUSE,
    parameter logic [4:0]  CP0_EPC_ADDR    = CP0_REG_EPC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic [7:0]  exc_flags_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] epc_pc_o,
    output logic        in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    logic [31:0] status_fwd, cause_fwd, epc_fwd;
    logic        int_pending;
    logic        exc_valid, exc_eret;
    logic [31:0] exc_code;
    bad_sel_e    exc_bad_sel;

    state_e      state_q, state_d;
    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] epc_pc_q, epc_pc_d;
    logic        in_delayslot_q, in_delayslot_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    // Only Cause.IP[1:0] are software-writable, so only those bits are forwarded.
    always_comb begin
        status_fwd = cp0_status_i;
        cause_fwd  = cp0_cause_i;
        epc_fwd    = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS_ADDR) status_fwd = wb_cp0_wdata_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE_ADDR) cause_fwd[9:8] = wb_cp0_wdata_i[9:8];
        if (wb_cp0_we_i && wb_cp0_waddr_i == CP0_EPC_ADDR) epc_fwd = wb_cp0_wdata_i;
    end

    assign int_pending = (|(cause_fwd[15:8] & status_fwd[15:8])) && status_fwd[0] &&
                         !status_fwd[1];

    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_fwd[31:16], status_fwd[7:2], cause_fwd[31:16],
                               cause_fwd[7:0]};

    exc_prio_enc u_exc_prio_enc (
        .int_pending_i (int_pending),
        .flags_i       (exc_flags_i),
        .valid_o       (exc_valid),
        .code_o        (exc_code),
        .bad_sel_o     (exc_bad_sel),
        .eret_o        (exc_eret)
    );

    // excepttype/flush default to 0 so a stall or FLUSH cycle never re-commits.
    always_comb begin
        state_d        = state_q;
        excepttype_d   = EXC_NONE;
        flush_d        = 1'b0;
        epc_pc_d       = epc_pc_q;
        in_delayslot_d = in_delayslot_q;
        bad_addr_d     = bad_addr_q;
        new_pc_d       = new_pc_q;
        unique case (state_q)
            StRun: begin
                if (mem_valid_i && !stall_i && exc_valid) begin
                    excepttype_d   = exc_code;
                    flush_d        = 1'b1;
                    epc_pc_d       = pc_i;
                    in_delayslot_d = in_delayslot_i;
                    new_pc_d       = exc_eret ? epc_fwd : EXC_VECTOR;
                    case (exc_bad_sel)
                        BadPc:   bad_addr_d = pc_i;
                        BadMem:  bad_addr_d = mem_addr_i;
                        default: bad_addr_d = bad_addr_q;
                    endcase
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!stall_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StRun;
            excepttype_q   <= '0;
            epc_pc_q       <= '0;
            in_delayslot_q <= 1'b0;
            bad_addr_q     <= '0;
            flush_q        <= 1'b0;
            new_pc_q       <= '0;
        end else begin
            state_q        <= state_d;
            excepttype_q   <= excepttype_d;
            epc_pc_q       <= epc_pc_d;
            in_delayslot_q <= in_delayslot_d;
            bad_addr_q     <= bad_addr_d;
            flush_q        <= flush_d;
            new_pc_q       <= new_pc_d;
        end
    end

    assign excepttype_o   = excepttype_q;
    assign epc_pc_o       = epc_pc_q;
    assign in_delayslot_o = in_delayslot_q;
    assign bad_addr_o     = bad_addr_q;
    assign flush_o        = flush_q;
    assign new_pc_o       = new_pc_q;

endmodule
